miriscv_hazard_ctrl: RTL and testbench
======================================

Name: miriscv_hazard_ctrl

Overview:
- Parametrised pipeline control unit for the miriscv core, taking over the stall/kill/boot logic currently embedded in the decode stage.
- Adds a load/store scoreboard that tracks up to MAX_OUTSTANDING in-flight data-memory transactions and interlocks decode on RAW/WAW hazards against pending load destinations.
- Sits beside the decode stage: it receives decoder fields and LSU/MDU status, and drives the fetch/decode stall and kill signals plus the load writeback address.

Parameters:
- GPR_ADDR_WIDTH, 5, register address width.
- BOOT_DELAY, 2, number of cycles after reset during which the boot address load is asserted (≥1).
- MAX_OUTSTANDING, 2, scoreboard depth, i.e. maximum in-flight memory transactions (≥1).
- CNT_WIDTH, 16, width of the stall-cycle performance counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- d_valid_i  in  1  decode holds a valid instruction
- d_rs1_addr_i / d_rs2_addr_i  in  GPR_ADDR_WIDTH each  source register addresses
- d_rs1_re_i / d_rs2_re_i  in  1 each  source register is read
- d_rd_addr_i  in  GPR_ADDR_WIDTH  destination register address
- d_wb_we_i  in  1  instruction writes rd
- d_mem_req_i  in  1  instruction is a load or store
- d_mem_we_i  in  1  store (1) / load (0)
- d_branch_i, d_jal_i, d_jalr_i  in  1 each  control-flow class
- branch_des_i  in  1  ALU branch condition true
- lsu_issue_i  in  1  LSU accepted a request this cycle (push)
- data_rvalid_i  in  1  memory response this cycle (pop, in order)
- lsu_stall_i, mdu_stall_i  in  1 each  unit busy
- cu_boot_addr_load_en_o  out  1  fetch loads boot address
- cu_stall_f_o, cu_stall_d_o  out  1 each  stall fetch / decode
- cu_kill_f_o  out  1  flush fetch
- lsu_wb_we_o  out  1  writeback of load data this cycle
- lsu_wb_rd_addr_o  out  GPR_ADDR_WIDTH  rd of the completing load
- sb_count_o  out  clog2(MAX_OUTSTANDING+1)  occupied scoreboard entries
- sb_overflow_o, sb_underflow_o  out  1 each  sticky error flags
- stall_cycles_o  out  CNT_WIDTH  saturating count of stalled cycles

Behaviour:
- Reset (rst_i sampled high at a clock edge) clears the boot counter, the scoreboard (count 0, all entries invalid), the error flags and stall_cycles_o.
  - After reset: cu_boot_addr_load_en_o=1, stalls=1, kill=0, lsu_wb_we_o=0, sb_count_o=0.
  - A reset arriving mid-transaction discards all pending entries; later rvalids with an empty scoreboard set sb_underflow_o.
- Boot: the counter increments from 0 and saturates at BOOT_DELAY. cu_boot_addr_load_en_o = (count < BOOT_DELAY). With BOOT_DELAY=2 it is high for exactly 2 cycles after reset deassertion.
- Scoreboard:
  - Circular FIFO of {valid, is_load, rd}.
  - Push on lsu_issue_i with {1, ~d_mem_we_i, d_rd_addr_i}. Pop head on data_rvalid_i.
  - Simultaneous push and pop is legal at any occupancy, including full; count is unchanged.
  - Push when full without a pop: entry dropped, sb_overflow_o set.
  - Pop when empty: ignored, sb_underflow_o set.
  - Pointers wrap modulo MAX_OUTSTANDING.
- Writeback (combinational from head): lsu_wb_we_o = data_rvalid_i & head.valid & head.is_load; lsu_wb_rd_addr_o = head.rd, and 0 when empty.
- Hazard:
  - hz = d_valid_i & OR over valid load entries with rd≠0 of:
    - (d_rs1_re_i & rs1==rd)
    - (d_rs2_re_i & rs2==rd)
    - (d_wb_we_i & d_rd_addr_i==rd)
  - Evaluation uses registered scoreboard contents, so a matching entry popped this cycle still stalls this cycle; the stall releases the next cycle.
- Full block: fb = d_valid_i & d_mem_req_i & (sb_count_o==MAX_OUTSTANDING) & ~data_rvalid_i.
- Stall: cu_stall_f_o = cu_stall_d_o = boot_en | hz | fb | lsu_stall_i | mdu_stall_i.
- Kill: cu_kill_f_o = d_valid_i & ~boot_en & ~hz & ((d_branch_i & branch_des_i) | d_jal_i | d_jalr_i). Kill is independent of lsu/mdu stall.
- stall_cycles_o increments each cycle cu_stall_d_o=1 after boot has completed, and saturates at all-ones.

Test Plan:
- Reset then idle, BOOT_DELAY=2: boot_en and stall high on cycles 0–1, low from cycle 2; stall_cycles_o stays 0.
- Load x5 issued (push), next instruction reads rs1=x5 → stall held until the cycle after rvalid. The rvalid cycle gives lsu_wb_we_o=1 and lsu_wb_rd_addr_o=5.
- Load to x0, next instruction reads x0 → no stall. The rvalid cycle gives lsu_wb_rd_addr_o=0.
- MAX_OUTSTANDING=2:
  - Two loads outstanding, third mem instruction → fb stall, sb_count_o=2.
  - rvalid arriving in the same cycle as the third push → count stays 2, no overflow.
  - Pointers wrap after 4 pushes.
- jalr with rs1 pending → kill=0 while hz. After release, kill pulses exactly 1 cycle; taken branch with branch_des_i=0 → no kill.
- rvalid with empty scoreboard → sb_underflow_o=1 and sticky until reset. Push on full without pop → sb_overflow_o=1.

Source files
------------

// File: rtl/miriscv_hazard_ctrl.sv
// Pipeline control for miriscv: boot sequencing, fetch/decode stall and kill,
// plus an in-order load/store scoreboard that interlocks decode on pending loads.
module miriscv_hazard_ctrl #(
  parameter int GPR_ADDR_WIDTH  = 5,
  parameter int BOOT_DELAY      = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               d_valid_i,
  input  logic [GPR_ADDR_WIDTH-1:0]          d_rs1_addr_i,
  input  logic [GPR_ADDR_WIDTH-1:0]          d_rs2_addr_i,
  input  logic                               d_rs1_re_i,
  input  logic                               d_rs2_re_i,
  input  logic [GPR_ADDR_WIDTH-1:0]          d_rd_addr_i,
  input  logic                               d_wb_we_i,
  input  logic                               d_mem_req_i,
  input  logic                               d_mem_we_i,
  input  logic                               d_branch_i,
  input  logic                               d_jal_i,
  input  logic                               d_jalr_i,
  input  logic                               branch_des_i,
  input  logic                               lsu_issue_i,
  input  logic                               data_rvalid_i,
  input  logic                               lsu_stall_i,
  input  logic                               mdu_stall_i,
  output logic                               cu_boot_addr_load_en_o,
  output logic                               cu_stall_f_o,
  output logic                               cu_stall_d_o,
  output logic                               cu_kill_f_o,
  output logic                               lsu_wb_we_o,
  output logic [GPR_ADDR_WIDTH-1:0]          lsu_wb_rd_addr_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] sb_count_o,
  output logic                               sb_overflow_o,
  output logic                               sb_underflow_o,
  output logic [CNT_WIDTH-1:0]               stall_cycles_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING+1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int BW = $clog2(BOOT_DELAY+1);

  typedef struct packed {
    logic                      valid;
    logic                      is_load;
    logic [GPR_ADDR_WIDTH-1:0] rd;
  } sb_entry_t;

  sb_entry_t     sb [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [BW-1:0] boot_cnt;
  logic          boot_en, empty, full, do_push, do_pop;
  logic          hz, fb, stall;
  sb_entry_t     head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING-1)) ? '0 : p + 1'b1;
  endfunction

  assign boot_en = boot_cnt < BW'(BOOT_DELAY);
  assign empty   = sb_count_o == '0;
  assign full    = sb_count_o == CW'(MAX_OUTSTANDING);
  assign do_pop  = data_rvalid_i & ~empty;
  // a pop in the same cycle frees the slot, so push is accepted even when full
  assign do_push = lsu_issue_i & (~full | do_pop);
  assign head    = sb[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      boot_cnt       <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      sb_count_o     <= '0;
      sb_overflow_o  <= 1'b0;
      sb_underflow_o <= 1'b0;
      stall_cycles_o <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) sb[i] <= '0;
    end else begin
      if (boot_en) boot_cnt <= boot_cnt + 1'b1;
      if (do_pop) begin
        sb[rd_ptr].valid <= 1'b0;
        rd_ptr           <= ptr_inc(rd_ptr);
      end
      // placed after the pop so a full push+pop onto the same slot keeps the new entry
      if (do_push) begin
        sb[wr_ptr] <= '{valid: 1'b1, is_load: ~d_mem_we_i, rd: d_rd_addr_i};
        wr_ptr     <= ptr_inc(wr_ptr);
      end
      sb_count_o <= sb_count_o + CW'(do_push) - CW'(do_pop);
      if (lsu_issue_i & full & ~data_rvalid_i) sb_overflow_o  <= 1'b1;
      if (data_rvalid_i & empty)               sb_underflow_o <= 1'b1;
      if (stall & ~boot_en & (stall_cycles_o != '1))
        stall_cycles_o <= stall_cycles_o + 1'b1;
    end
  end

  always_comb begin
    hz = 1'b0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (sb[i].valid && sb[i].is_load && (sb[i].rd != '0) &&
          ((d_rs1_re_i && (d_rs1_addr_i == sb[i].rd)) ||
           (d_rs2_re_i && (d_rs2_addr_i == sb[i].rd)) ||
           (d_wb_we_i  && (d_rd_addr_i  == sb[i].rd))))
        hz = 1'b1;
    end
    hz = hz & d_valid_i;
  end

  assign fb    = d_valid_i & d_mem_req_i & full & ~data_rvalid_i;
  assign stall = boot_en | hz | fb | lsu_stall_i | mdu_stall_i;

  assign cu_boot_addr_load_en_o = boot_en;
  assign cu_stall_f_o           = stall;
  assign cu_stall_d_o           = stall;
  assign cu_kill_f_o            = d_valid_i & ~boot_en & ~hz &
                                  ((d_branch_i & branch_des_i) | d_jal_i | d_jalr_i);
  assign lsu_wb_we_o            = data_rvalid_i & head.valid & head.is_load;
  assign lsu_wb_rd_addr_o       = head.valid ? head.rd : '0;

endmodule

// File: tb/tb_miriscv_hazard_ctrl.sv
// Self-checking bench for miriscv_hazard_ctrl: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_miriscv_hazard_ctrl;
  localparam int BD = 2, MO = 2, AW = 5, CN = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_i, d_valid_i, d_rs1_re_i, d_rs2_re_i, d_wb_we_i, d_mem_req_i, d_mem_we_i;
  logic d_branch_i, d_jal_i, d_jalr_i, branch_des_i, lsu_issue_i, data_rvalid_i;
  logic lsu_stall_i, mdu_stall_i;
  logic [AW-1:0] d_rs1_addr_i, d_rs2_addr_i, d_rd_addr_i;
  logic boot_o, stall_f_o, stall_d_o, kill_o, wb_we_o, ovf_o, udf_o;
  logic [AW-1:0] wb_rd_o;
  logic [1:0]    cnt_o;
  logic [CN-1:0] sc_o;

  miriscv_hazard_ctrl #(.GPR_ADDR_WIDTH(AW), .BOOT_DELAY(BD), .MAX_OUTSTANDING(MO), .CNT_WIDTH(CN)) dut (
    .clk_i(clk), .rst_i(rst_i), .d_valid_i(d_valid_i),
    .d_rs1_addr_i(d_rs1_addr_i), .d_rs2_addr_i(d_rs2_addr_i),
    .d_rs1_re_i(d_rs1_re_i), .d_rs2_re_i(d_rs2_re_i),
    .d_rd_addr_i(d_rd_addr_i), .d_wb_we_i(d_wb_we_i),
    .d_mem_req_i(d_mem_req_i), .d_mem_we_i(d_mem_we_i),
    .d_branch_i(d_branch_i), .d_jal_i(d_jal_i), .d_jalr_i(d_jalr_i),
    .branch_des_i(branch_des_i), .lsu_issue_i(lsu_issue_i), .data_rvalid_i(data_rvalid_i),
    .lsu_stall_i(lsu_stall_i), .mdu_stall_i(mdu_stall_i),
    .cu_boot_addr_load_en_o(boot_o), .cu_stall_f_o(stall_f_o), .cu_stall_d_o(stall_d_o),
    .cu_kill_f_o(kill_o), .lsu_wb_we_o(wb_we_o), .lsu_wb_rd_addr_o(wb_rd_o),
    .sb_count_o(cnt_o), .sb_overflow_o(ovf_o), .sb_underflow_o(udf_o),
    .stall_cycles_o(sc_o)
  );

  // reference model: in-order queue of outstanding transactions
  typedef struct { bit is_load; bit [AW-1:0] rd; } txn_t;
  txn_t q[$];
  int   m_cyc;
  bit   m_ovf, m_udf;
  logic [CN-1:0] m_sc;
  logic e_boot, e_stall, e_kill, e_wbwe, e_ovf, e_udf;
  logic [AW-1:0] e_wbrd;
  logic [1:0]    e_cnt;
  logic [CN-1:0] e_sc;
  int n_chk = 0, n_err = 0;

  function automatic void model_eval();
    bit hz = 0, fb;
    foreach (q[i])
      if (q[i].is_load && q[i].rd != 0 &&
          ((d_rs1_re_i && d_rs1_addr_i == q[i].rd) || (d_rs2_re_i && d_rs2_addr_i == q[i].rd) ||
           (d_wb_we_i && d_rd_addr_i == q[i].rd))) hz = 1;
    hz      = hz && d_valid_i;
    fb      = d_valid_i && d_mem_req_i && q.size() == MO && !data_rvalid_i;
    e_boot  = m_cyc < BD;
    e_stall = e_boot || hz || fb || lsu_stall_i || mdu_stall_i;
    e_kill  = d_valid_i && !e_boot && !hz && ((d_branch_i && branch_des_i) || d_jal_i || d_jalr_i);
    e_wbwe  = 0;
    e_wbrd  = 0;
    if (q.size() > 0) begin
      e_wbwe = data_rvalid_i && q[0].is_load;
      e_wbrd = q[0].rd;
    end
    e_cnt = 2'(q.size());
    e_ovf = m_ovf; e_udf = m_udf; e_sc = m_sc;
  endfunction

  function automatic void model_update();
    model_eval();
    if (e_stall && !e_boot && m_sc != '1) m_sc = m_sc + 1'b1;
    if (m_cyc < BD) m_cyc++;
    if (data_rvalid_i) begin
      if (q.size() > 0) void'(q.pop_front());
      else m_udf = 1;
    end
    if (lsu_issue_i) begin
      if (q.size() < MO) q.push_back('{is_load: !d_mem_we_i, rd: d_rd_addr_i});
      else m_ovf = 1;
    end
  endfunction

  function automatic void model_reset();
    q.delete(); m_cyc = 0; m_ovf = 0; m_udf = 0; m_sc = '0;
  endfunction

  task automatic idle();
    d_valid_i = 0; d_rs1_re_i = 0; d_rs2_re_i = 0; d_wb_we_i = 0; d_mem_req_i = 0; d_mem_we_i = 0;
    d_branch_i = 0; d_jal_i = 0; d_jalr_i = 0; branch_des_i = 0; lsu_issue_i = 0;
    data_rvalid_i = 0; lsu_stall_i = 0; mdu_stall_i = 0;
    d_rs1_addr_i = 0; d_rs2_addr_i = 0; d_rd_addr_i = 0;
  endtask

  task automatic settle();
    #1; model_eval();
  endtask

  task automatic tick();
    if (rst_i) model_reset(); else model_update();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); rst_i = 1; tick(); tick(); rst_i = 0;
  endtask

  task automatic test_reset();
    do_reset(); settle();
    n_chk++; if (boot_o !== 1'b1)  begin n_err++; $display("FAIL rst_boot0 got=%b exp=1", boot_o); end
    n_chk++; if (stall_d_o !== 1'b1 || stall_f_o !== 1'b1) begin n_err++; $display("FAIL rst_stall0 got=%b%b exp=11", stall_f_o, stall_d_o); end
    n_chk++; if (kill_o !== 1'b0 || wb_we_o !== 1'b0) begin n_err++; $display("FAIL rst_kill_wb got=%b%b exp=00", kill_o, wb_we_o); end
    n_chk++; if (cnt_o !== 2'd0 || ovf_o !== 1'b0 || udf_o !== 1'b0) begin n_err++; $display("FAIL rst_sb got=%0d/%b/%b exp=0/0/0", cnt_o, ovf_o, udf_o); end
    tick(); settle();
    n_chk++; if (boot_o !== 1'b1)  begin n_err++; $display("FAIL rst_boot1 got=%b exp=1", boot_o); end
    tick(); settle();
    n_chk++; if (boot_o !== 1'b0 || stall_d_o !== 1'b0) begin n_err++; $display("FAIL rst_boot2 got=%b/%b exp=0/0", boot_o, stall_d_o); end
    tick(); tick(); tick(); settle();
    n_chk++; if (sc_o !== '0) begin n_err++; $display("FAIL rst_stallcnt got=%0d exp=0", sc_o); end
  endtask

  task automatic test_load_use();
    idle(); d_valid_i = 1; d_mem_req_i = 1; d_wb_we_i = 1; d_rd_addr_i = 5; lsu_issue_i = 1; settle();
    n_chk++; if (stall_d_o !== 1'b0) begin n_err++; $display("FAIL lu_issue_stall got=%b exp=0", stall_d_o); end
    tick();
    idle(); d_valid_i = 1; d_rs1_re_i = 1; d_rs1_addr_i = 5; d_wb_we_i = 1; d_rd_addr_i = 6; settle();
    n_chk++; if (stall_d_o !== 1'b1 || cnt_o !== 2'd1) begin n_err++; $display("FAIL lu_hold got=%b/%0d exp=1/1", stall_d_o, cnt_o); end
    tick(); data_rvalid_i = 1; settle();
    n_chk++; if (stall_d_o !== 1'b1 || wb_we_o !== 1'b1 || wb_rd_o !== 5'd5) begin n_err++; $display("FAIL lu_rvalid got=%b/%b/%0d exp=1/1/5", stall_d_o, wb_we_o, wb_rd_o); end
    tick(); data_rvalid_i = 0; settle();
    n_chk++; if (stall_d_o !== 1'b0 || cnt_o !== 2'd0) begin n_err++; $display("FAIL lu_release got=%b/%0d exp=0/0", stall_d_o, cnt_o); end
    tick();
  endtask

  task automatic test_x0();
    idle(); d_valid_i = 1; d_mem_req_i = 1; d_wb_we_i = 1; d_rd_addr_i = 0; lsu_issue_i = 1; tick();
    idle(); d_valid_i = 1; d_rs1_re_i = 1; d_rs2_re_i = 1; settle();
    n_chk++; if (stall_d_o !== 1'b0) begin n_err++; $display("FAIL x0_stall got=%b exp=0", stall_d_o); end
    data_rvalid_i = 1; settle();
    n_chk++; if (wb_we_o !== 1'b1 || wb_rd_o !== 5'd0) begin n_err++; $display("FAIL x0_wb got=%b/%0d exp=1/0", wb_we_o, wb_rd_o); end
    tick(); idle();
  endtask

  task automatic test_full();
    for (int r = 1; r <= 2; r++) begin
      idle(); d_valid_i = 1; d_mem_req_i = 1; d_wb_we_i = 1; d_rd_addr_i = 5'(r); lsu_issue_i = 1; tick();
    end
    idle(); d_valid_i = 1; d_mem_req_i = 1; d_wb_we_i = 1; d_rd_addr_i = 3; settle();
    n_chk++; if (stall_d_o !== 1'b1 || cnt_o !== 2'd2) begin n_err++; $display("FAIL full_block got=%b/%0d exp=1/2", stall_d_o, cnt_o); end
    tick(); lsu_issue_i = 1; data_rvalid_i = 1; settle();
    n_chk++; if (stall_d_o !== 1'b0 || wb_rd_o !== 5'd1) begin n_err++; $display("FAIL full_pushpop got=%b/%0d exp=0/1", stall_d_o, wb_rd_o); end
    tick(); d_rd_addr_i = 4; settle();
    n_chk++; if (cnt_o !== 2'd2 || ovf_o !== 1'b0) begin n_err++; $display("FAIL full_keep got=%0d/%b exp=2/0", cnt_o, ovf_o); end
    n_chk++; if (wb_rd_o !== 5'd2) begin n_err++; $display("FAIL full_head2 got=%0d exp=2", wb_rd_o); end
    tick(); idle(); data_rvalid_i = 1; settle();
    n_chk++; if (wb_rd_o !== 5'd3) begin n_err++; $display("FAIL wrap_head3 got=%0d exp=3", wb_rd_o); end
    tick(); settle();
    n_chk++; if (wb_rd_o !== 5'd4 || wb_we_o !== 1'b1) begin n_err++; $display("FAIL wrap_head4 got=%0d/%b exp=4/1", wb_rd_o, wb_we_o); end
    tick(); idle(); settle();
    n_chk++; if (cnt_o !== 2'd0 || udf_o !== 1'b0) begin n_err++; $display("FAIL wrap_drain got=%0d/%b exp=0/0", cnt_o, udf_o); end
  endtask

  task automatic test_kill();
    idle(); d_valid_i = 1; d_mem_req_i = 1; d_wb_we_i = 1; d_rd_addr_i = 7; lsu_issue_i = 1; tick();
    idle(); d_valid_i = 1; d_jalr_i = 1; d_rs1_re_i = 1; d_rs1_addr_i = 7; d_wb_we_i = 1; d_rd_addr_i = 1; settle();
    n_chk++; if (kill_o !== 1'b0 || stall_d_o !== 1'b1) begin n_err++; $display("FAIL kill_hz got=%b/%b exp=0/1", kill_o, stall_d_o); end
    tick(); data_rvalid_i = 1; settle();
    n_chk++; if (kill_o !== 1'b0) begin n_err++; $display("FAIL kill_popcycle got=%b exp=0", kill_o); end
    tick(); data_rvalid_i = 0; settle();
    n_chk++; if (kill_o !== 1'b1 || stall_d_o !== 1'b0) begin n_err++; $display("FAIL kill_release got=%b/%b exp=1/0", kill_o, stall_d_o); end
    tick(); idle(); settle();
    n_chk++; if (kill_o !== 1'b0) begin n_err++; $display("FAIL kill_pulse got=%b exp=0", kill_o); end
    d_valid_i = 1; d_branch_i = 1; branch_des_i = 0; settle();
    n_chk++; if (kill_o !== 1'b0) begin n_err++; $display("FAIL kill_nottaken got=%b exp=0", kill_o); end
    branch_des_i = 1; lsu_stall_i = 1; settle();
    n_chk++; if (kill_o !== 1'b1 || stall_d_o !== 1'b1) begin n_err++; $display("FAIL kill_lsustall got=%b/%b exp=1/1", kill_o, stall_d_o); end
    tick(); idle();
  endtask

  task automatic test_errors();
    idle(); data_rvalid_i = 1; tick(); idle(); settle();
    n_chk++; if (udf_o !== 1'b1) begin n_err++; $display("FAIL udf_set got=%b exp=1", udf_o); end
    tick(); tick(); tick(); settle();
    n_chk++; if (udf_o !== 1'b1) begin n_err++; $display("FAIL udf_sticky got=%b exp=1", udf_o); end
    for (int r = 9; r <= 11; r++) begin
      idle(); d_mem_req_i = 1; d_rd_addr_i = 5'(r); lsu_issue_i = 1; tick();
    end
    idle(); settle();
    n_chk++; if (ovf_o !== 1'b1 || cnt_o !== 2'd2) begin n_err++; $display("FAIL ovf_set got=%b/%0d exp=1/2", ovf_o, cnt_o); end
    do_reset(); settle();
    n_chk++; if (ovf_o !== 1'b0 || udf_o !== 1'b0 || cnt_o !== 2'd0) begin n_err++; $display("FAIL rst_mid got=%b/%b/%0d exp=0/0/0", ovf_o, udf_o, cnt_o); end
    tick(); tick(); data_rvalid_i = 1; settle();
    n_chk++; if (wb_we_o !== 1'b0) begin n_err++; $display("FAIL rst_discard_wb got=%b exp=0", wb_we_o); end
    tick(); idle(); settle();
    n_chk++; if (udf_o !== 1'b1) begin n_err++; $display("FAIL rst_discard_udf got=%b exp=1", udf_o); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_i         = ($urandom_range(0, 199) == 0);
      d_valid_i     = ($urandom_range(0, 99) < 80);
      d_rs1_re_i    = $urandom_range(0, 1) == 1;
      d_rs2_re_i    = $urandom_range(0, 1) == 1;
      d_wb_we_i     = $urandom_range(0, 1) == 1;
      d_mem_req_i   = $urandom_range(0, 1) == 1;
      d_mem_we_i    = $urandom_range(0, 2) == 0;
      d_branch_i    = ($urandom_range(0, 99) < 20);
      d_jal_i       = ($urandom_range(0, 99) < 10);
      d_jalr_i      = ($urandom_range(0, 99) < 10);
      branch_des_i  = $urandom_range(0, 1) == 1;
      lsu_issue_i   = ($urandom_range(0, 99) < 35);
      data_rvalid_i = ($urandom_range(0, 99) < 35);
      lsu_stall_i   = ($urandom_range(0, 99) < 5);
      mdu_stall_i   = ($urandom_range(0, 99) < 5);
      d_rs1_addr_i  = 5'($urandom_range(0, 7));
      d_rs2_addr_i  = 5'($urandom_range(0, 7));
      d_rd_addr_i   = 5'($urandom_range(0, 7));
      settle();
      n_chk++; if (boot_o !== e_boot) begin n_err++; $display("FAIL rnd_boot c=%0d got=%b exp=%b", c, boot_o, e_boot); end
      n_chk++; if (stall_d_o !== e_stall || stall_f_o !== e_stall) begin n_err++; $display("FAIL rnd_stall c=%0d got=%b%b exp=%b", c, stall_f_o, stall_d_o, e_stall); end
      n_chk++; if (kill_o !== e_kill) begin n_err++; $display("FAIL rnd_kill c=%0d got=%b exp=%b", c, kill_o, e_kill); end
      n_chk++; if (wb_we_o !== e_wbwe || wb_rd_o !== e_wbrd) begin n_err++; $display("FAIL rnd_wb c=%0d got=%b/%0d exp=%b/%0d", c, wb_we_o, wb_rd_o, e_wbwe, e_wbrd); end
      n_chk++; if (cnt_o !== e_cnt) begin n_err++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, cnt_o, e_cnt); end
      n_chk++; if (ovf_o !== e_ovf || udf_o !== e_udf) begin n_err++; $display("FAIL rnd_flags c=%0d got=%b/%b exp=%b/%b", c, ovf_o, udf_o, e_ovf, e_udf); end
      n_chk++; if (sc_o !== e_sc) begin n_err++; $display("FAIL rnd_stallcnt c=%0d got=%0d exp=%0d", c, sc_o, e_sc); end
      tick();
    end
    rst_i = 0; idle();
  endtask

  initial begin
    idle(); rst_i = 1; model_reset();
    test_reset();
    test_load_use();
    test_x0();
    test_full();
    test_kill();
    test_errors();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
